// File: rtl/tick_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen_pkg
// Description : Shared types and default game-rate divide values for the
//               programmable tick generator (25 MHz system clock).
// Revision    : 1.0 - initial release
// ============================================================================
package tick_gen_pkg;

    // Channel behaviour after its counter reaches zero
    typedef enum logic {
        TICK_PERIODIC = 1'b0,
        TICK_ONESHOT  = 1'b1
    } tick_mode_e;

    // Default divide values D (period D+1 cycles) at 25 MHz
    localparam int unsigned c_div_ball   = 32'd249_999;     // 100 Hz ball step
    localparam int unsigned c_div_paddle = 32'd124_999;     // 200 Hz paddle step
    localparam int unsigned c_div_ai     = 32'd833_332;     // ~30 Hz AI reaction
    localparam int unsigned c_div_blink  = 32'd12_499_999;  // 2 Hz score blink

endpackage : tick_gen_pkg
`default_nettype wire

// File: rtl/tick_chan.sv
`default_nettype none
// ============================================================================
// Module      : tick_chan
// Description : One tick channel: programmable down-counter emitting a
//               single-cycle registered strobe every D+1 enabled cycles, or
//               once per arm in one-shot mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_mode,
    input  logic             i_en,
    output logic             o_tick,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    tick_mode_e       r_mode;
    logic             r_armed;
    logic             r_en_q;
    logic             r_tick;
    logic             w_rise;

    // A rising enable restarts the period from the stored divide value
    assign w_rise = i_en & ~r_en_q;

    // Config write has priority over the enable edge, which has priority
    // over normal counting; a write in a due cycle suppresses that tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_mode  <= TICK_PERIODIC;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_en_q  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_en_q <= i_en;
            r_tick <= 1'b0;
            if (i_wr) begin
                r_div   <= i_div;
                r_mode  <= tick_mode_e'(i_mode);
                r_cnt   <= i_div;
                r_armed <= 1'b1;
            end else if (w_rise) begin
                r_cnt   <= r_div;
                r_armed <= 1'b1;
            end else if (i_en && r_armed) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_one;
                end else begin
                    r_tick <= 1'b1;
                    if (r_mode == TICK_PERIODIC) begin
                        r_cnt <= r_div;
                    end else begin
                        r_armed <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_tick = r_tick;
    assign o_busy = i_en & r_armed;

endmodule : tick_chan
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Multi-channel programmable clock-enable generator with a
//               shared configuration port and a free-running counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26,
    parameter int FREE_W = 32
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         cfg_we,
    input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]                             cfg_div,
    input  logic                                         cfg_mode,
    input  logic [NUM_CH-1:0]                            ch_en,
    output logic [NUM_CH-1:0]                            tick,
    output logic [NUM_CH-1:0]                            busy,
    output logic [FREE_W-1:0]                            free_cnt
);

    localparam int CH_W = $clog2(NUM_CH > 1 ? NUM_CH : 2);

    logic [NUM_CH-1:0] w_wr;
    logic [FREE_W-1:0] r_free;

    // One channel per bit; a channel index outside the bank matches no decode
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_wr[k] = cfg_we & (cfg_ch == CH_W'(k));

        tick_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst    (reset),
            .i_wr   (w_wr[k]),
            .i_div  (cfg_div),
            .i_mode (cfg_mode),
            .i_en   (ch_en[k]),
            .o_tick (tick[k]),
            .o_busy (busy[k])
        );
    end

    // Free-running counter for legacy taps of raw divided bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_free <= '0;
        end else begin
            r_free <= r_free + FREE_W'(1);
        end
    end

    assign free_cnt = r_free;

endmodule : tick_gen
`default_nettype wire

// File: tb/tb_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_gen
// Description : Scoreboard bench for tick_gen: an absolute-time reference
//               model predicts each cycle's outputs, a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_gen;

    localparam int NCH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [25:0] cfg_div = '0;
    logic        cfg_mode = 1'b0;
    logic [2:0]  ch_en = '0;
    logic [2:0]  tick;
    logic [2:0]  busy;
    logic [31:0] free_cnt;

    // narrow free counter instance
    logic        z_we = 1'b0;
    logic [0:0]  z_ch = '0;
    logic [25:0] z_div = '0;
    logic        z_mode = 1'b0;
    logic [0:0]  z_en = '0;
    logic [0:0]  u4_tick;
    logic [0:0]  u4_busy;
    logic [3:0]  u4_free;

    always #5 clk = ~clk;

    tick_gen #(.NUM_CH(NCH), .CNT_W(26), .FREE_W(32)) dut (
        .clk(clk), .reset(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .ch_en(ch_en),
        .tick(tick), .busy(busy), .free_cnt(free_cnt)
    );

    tick_gen #(.NUM_CH(1), .CNT_W(26), .FREE_W(4)) dut4 (
        .clk(clk), .reset(rst), .cfg_we(z_we), .cfg_ch(z_ch),
        .cfg_div(z_div), .cfg_mode(z_mode), .ch_en(z_en),
        .tick(u4_tick), .busy(u4_busy), .free_cnt(u4_free)
    );

    typedef struct {
        int unsigned e;
        logic [2:0]  tick;
        logic [2:0]  busy;
        logic [31:0] free;
        logic [3:0]  free4;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // reference model: each armed channel knows the absolute edge of its next tick
    int unsigned edge_n = 0;
    int unsigned m_div[NCH];
    bit          m_mode[NCH];
    bit          m_armed[NCH];
    longint      m_next[NCH];
    bit          m_prev[NCH];
    logic [2:0]  m_tick = '0;
    int unsigned m_free = 0;

    // ch0 tick counting window (edge numbers)
    int unsigned win_lo = 1;
    int unsigned win_hi = 0;
    int          win_cnt = 0;

    task automatic chk(string nm, int unsigned e, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s after edge %0d: got %0h, expected %0h", nm, e, act, exp);
        end
    endtask

    task automatic model_edge();
        edge_n++;
        m_tick = '0;
        if (rst) begin
            m_free = 0;
            for (int k = 0; k < NCH; k++) begin
                m_div[k] = 0; m_mode[k] = 0; m_armed[k] = 0;
                m_next[k] = 0; m_prev[k] = 0;
            end
        end else begin
            m_free++;
            for (int k = 0; k < NCH; k++) begin
                bit wr;
                bit rise;
                wr   = cfg_we && (int'(cfg_ch) == k);
                rise = ch_en[k] && !m_prev[k];
                if (wr) begin
                    m_div[k]   = int'(cfg_div);
                    m_mode[k]  = cfg_mode;
                    m_armed[k] = 1;
                    m_next[k]  = longint'(edge_n) + longint'(m_div[k]) + 1;
                end else if (rise) begin
                    m_armed[k] = 1;
                    m_next[k]  = longint'(edge_n) + longint'(m_div[k]) + 1;
                end else if (ch_en[k] && m_armed[k] && longint'(edge_n) == m_next[k]) begin
                    m_tick[k] = 1'b1;
                    if (!m_mode[k]) m_next[k] = longint'(edge_n) + longint'(m_div[k]) + 1;
                    else m_armed[k] = 0;
                end
                m_prev[k] = ch_en[k];
            end
        end
    endtask

    // one clock: model the edge with the held inputs, then present the next inputs
    task automatic step(bit nr, bit nwe, logic [1:0] nch, logic [25:0] ndiv,
                        bit nmode, logic [2:0] nen);
        exp_t x;
        @(posedge clk);
        model_edge();
        #1;
        rst = nr; cfg_we = nwe; cfg_ch = nch; cfg_div = ndiv;
        cfg_mode = nmode; ch_en = nen;
        x.e     = edge_n;
        x.tick  = m_tick;
        for (int k = 0; k < NCH; k++) x.busy[k] = ch_en[k] & m_armed[k];
        x.free  = m_free;
        x.free4 = 4'(m_free % 16);
        q.push_back(x);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 26'd0, 0, ch_en);
    endtask

    task automatic wr(logic [1:0] ch, logic [25:0] d, bit mode, logic [2:0] en);
        step(0, 1, ch, d, mode, en);
    endtask

    // monitor: every sampled cycle is an output to compare
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("tick", x.e, longint'(tick), longint'(x.tick));
                chk("busy", x.e, longint'(busy), longint'(x.busy));
                chk("free_cnt", x.e, longint'(free_cnt), longint'(x.free));
                chk("free_cnt_w4", x.e, longint'(u4_free), longint'(x.free4));
                if (x.e >= win_lo && x.e <= win_hi && tick[0]) win_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // reset, then idle long enough to see the 4-bit counter wrap
        step(1, 0, 2'd0, 26'd0, 0, 3'b000);
        step(0, 0, 2'd0, 26'd0, 0, 3'b000);
        idle(20);

        // ch0 periodic D=3, count ticks over 100 cycles after the write edge
        wr(2'd0, 26'd3, 0, 3'b001);
        win_lo = edge_n + 2;
        win_hi = edge_n + 101;
        win_cnt = 0;
        idle(102);
        vectors++;
        if (win_cnt < 24 || win_cnt > 26) begin
            miscompares++;
            $display("FAIL ch0_tick_count: got %0d, expected 25 +/-1", win_cnt);
        end

        // ch1 periodic D=0, drop enable for 5 cycles
        wr(2'd1, 26'd0, 0, 3'b011);
        idle(10);
        for (int i = 0; i < 5; i++) step(0, 0, 2'd0, 26'd0, 0, 3'b001);
        step(0, 0, 2'd0, 26'd0, 0, 3'b011);
        idle(10);

        // ch2 one-shot D=5, then re-arm via enable toggle
        wr(2'd2, 26'd5, 1, 3'b111);
        idle(10);
        step(0, 0, 2'd0, 26'd0, 0, 3'b011);
        step(0, 0, 2'd0, 26'd0, 0, 3'b011);
        step(0, 0, 2'd0, 26'd0, 0, 3'b111);
        idle(10);

        // rewrite ch0 with D=7 exactly on the edge its D=3 tick is due
        guard = 0;
        while (m_next[0] != longint'(edge_n) + 2 && guard < 10) begin
            idle(1);
            guard++;
        end
        vectors++;
        if (guard >= 10) begin
            miscompares++;
            $display("FAIL ch0_due_search: got no due edge, expected one within 10 cycles");
        end
        wr(2'd0, 26'd7, 0, 3'b111);
        idle(20);

        // out-of-range channel write must change nothing
        wr(2'd3, 26'd1, 1, 3'b111);
        idle(20);

        // reset while all channels count mid-period
        wr(2'd0, 26'd5, 0, 3'b111);
        wr(2'd1, 26'd2, 0, 3'b111);
        wr(2'd2, 26'd4, 1, 3'b111);
        idle(3);
        step(1, 0, 2'd0, 26'd0, 0, 3'b111);
        step(0, 0, 2'd0, 26'd0, 0, 3'b111);
        idle(12);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] ne;
            ne = ch_en;
            for (int b = 0; b < NCH; b++)
                if ($urandom_range(0, 11) == 0) ne[b] = ~ne[b];
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
                 2'($urandom_range(0, 3)), 26'($urandom_range(0, 9)),
                 1'($urandom_range(0, 1)), ne);
        end

        repeat (3) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_tick_gen
`default_nettype wire
